// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared state encoding and counter sizing for the bit-serial adder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The bit counter only has to reach WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_if.sv
// ============================================================================
// Module  : serial_adder_if
// Brief   : Operand and result handshakes of the bit-serial adder.
//           With SERIAL_ADDER_SUB_EN defined it also carries the sub select.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder_full_add.sv
// ============================================================================
// Module  : full_add
// Brief   : 1-bit full-adder cell used as the bit slice of the serial adder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module full_add (
  input  wire logic a,
  input  wire logic b,
  input  wire logic c,
  output logic      sum,
  output logic      carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : LSB-first bit-serial WIDTH-bit adder around one full-adder cell.
//           Optional macro SERIAL_ADDER_SUB_EN adds a subtract mode (a-b).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input wire logic      clk,
  input wire logic      rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_count;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic             w_accept;
  logic             w_last;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = bus.sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1; cin is ignored in that mode.
  assign w_b_load = w_sub ? ~bus.b : bus.b;
  assign w_c_load = w_sub ? 1'b1   : bus.cin;

  assign w_accept = (r_state == ST_IDLE) && bus.in_valid && !rst;
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));

  full_add u_full_add (
    .a     (r_a_sr[0]),
    .b     (r_b_sr[0]),
    .c     (r_carry),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        bus.in_ready = !rst;
        if (bus.in_valid) w_next = ST_RUN;
      end
      ST_RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a_sr  <= bus.a;
      r_b_sr  <= w_b_load;
      r_carry <= w_c_load;
      r_count <= '0;
    end else if (r_state == ST_RUN) begin
      r_s_sr  <= {w_fa_sum, r_s_sr[WIDTH-1:1]};
      r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_carry <= w_fa_carry;
      r_count <= r_count + CNT_W'(1);
      if (w_last) begin
        r_sum  <= {w_fa_sum, r_s_sr[WIDTH-1:1]};
        r_cout <= w_fa_carry;
      end
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Directed self-checking bench for serial_adder at WIDTH=8.
//           Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with out_ready high; checks latency, result and handoff.
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec);
    int n;
    bus.a = va; bus.b = vb; bus.cin = vc;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin tick(); n++; end
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.out_valid && n < 40) begin tick(); n++; end
    check({tag, "_lat"}, 32'(n), 32'd8);
    check({tag, "_sum"}, 32'(bus.sum), 32'(es));
    check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    tick();
    check({tag, "_ovdrop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_rdyback"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Back-to-back table: a, b, cin, sum, cout
  logic [7:0] bb_a   [10] = '{8'h01, 8'h80, 8'h7F, 8'hAA, 8'h0F, 8'hC3, 8'h99, 8'h64, 8'hFE, 8'h00};
  logic [7:0] bb_b   [10] = '{8'h02, 8'h80, 8'h01, 8'h55, 8'hF0, 8'h3C, 8'h66, 8'h64, 8'hFE, 8'h00};
  logic       bb_c   [10] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
  logic [7:0] bb_s   [10] = '{8'h03, 8'h00, 8'h80, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hC8, 8'hFD, 8'h01};
  logic       bb_co  [10] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};

  initial begin
    int n;
    int t_prev;
    logic seen;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    t_prev = 0;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_op("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    run_op("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("addff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure: result held, new operands ignored while in DONE
    bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin tick(); n++; end
    check("bp_lat", 32'(n), 32'd8);
    bus.a = 8'h77; bus.b = 8'h11; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_sum_hold", 32'(bus.sum), 32'h46);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    check("bp_handoff", 32'(bus.out_valid), 32'd0);
    tick();
    check("bp_no_queue", 32'(bus.busy), 32'd0);

    // Reset in the middle of RUN
    bus.a = 8'h55; bus.b = 8'h0F; bus.cin = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    check("mid_rst_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready_back", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen = seen | bus.out_valid;
      tick();
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);

    // Back-to-back with in_valid and out_ready held high
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.a = bb_a[i]; bus.b = bb_b[i]; bus.cin = bb_c[i];
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 40) begin tick(); n++; end
      check("b2b_rdy", 32'(bus.in_ready), 32'd1);
      tick();
      if (i > 0) check("b2b_spacing", 32'(cyc - t_prev), 32'd10);
      t_prev = cyc;
      n = 0;
      while (!bus.out_valid && n < 40) begin tick(); n++; end
      check("b2b_sum", 32'(bus.sum), 32'(bb_s[i]));
      check("b2b_cout", 32'(bus.cout), 32'(bb_co[i]));
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (12) tick();

`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b1;
    run_op("sub10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
    run_op("sub01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    bus.sub = 1'b0;
    run_op("sub_off", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that wraps a single 1-bit full-adder cell with operand shift registers and a carry flip-flop.
- Accepts two WIDTH-bit operands over a valid/ready handshake and adds them LSB-first, one bit per clock.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Trades latency for area; it is the sequential datapath stage built directly on the full-adder cell.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands/cin presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  final carry-out.
- busy  output  1  high in RUN.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, sum=0, cout=0, busy=0, internal shift regs/count/carry=0. in_ready=0 while rst is high, 1 in the first cycle after reset.
- State IDLE:
  - in_ready = 1.
  - On a clk edge with in_valid&in_ready: load A_sr<=a, B_sr<=b, carry<=cin, count<=0, go to RUN.
- State RUN:
  - in_ready = 0, busy = 1.
  - Each edge: fa_sum/fa_carry = full-add(A_sr[0], B_sr[0], carry).
  - S_sr <= {fa_sum, S_sr[WIDTH-1:1]}; A_sr, B_sr shift right by 1 (zero-fill); carry <= fa_carry; count <= count+1.
  - When count==WIDTH-1 on that edge, go to DONE; sum takes the final S_sr and cout takes fa_carry.
- State DONE:
  - out_valid = 1; sum and cout held stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
- Latency: out_valid rises exactly WIDTH clocks after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high. No overlap: in_ready stays 0 from accept until result handoff.
- Result:
  - sum = (a+b+cin) mod 2^WIDTH.
  - cout = bit WIDTH of a+b+cin (count width = clog2(WIDTH)).
- Boundary conditions:
  - in_valid while not in IDLE: ignored, not queued.
  - out_ready high in IDLE or RUN: no effect.
  - rst in any state aborts to IDLE with reset values next cycle; a partial result is never presented.
  - sum/cout retain the last result after handoff until the next DONE; consumers must qualify with out_valid.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands at accept.
  - sub=1: B_sr loaded with ~b and carry seeded with 1 (cin ignored), so sum = a-b mod 2^WIDTH and cout=1 means no borrow.
  - sub=0: behaves as the plain adder.
- Undefined: no sub port; add only.

Decomposition:
- Package serial_adder_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and CNT_W=$clog2(WIDTH) helper function.
- Sub-module: the team's 1-bit full-adder cell full_add (a,b,c -> sum,carry), instantiated once as the bit-slice.
- Shift registers, counter and FSM stay in serial_adder.

Test Plan (WIDTH=8):
- a=0x35, b=0x4A, cin=0, out_ready=1 -> out_valid exactly 8 cycles after accept; sum=0x7F, cout=0; in_ready back to 1 two cycles later.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: a=0x12, b=0x34, out_ready=0 for 5 cycles after out_valid -> sum=0x46 held stable, in_ready=0 throughout, a second in_valid is ignored; handoff on out_ready=1.
- Reset mid-operation: rst pulsed at RUN count=4 -> out_valid never asserts for that operation, all outputs reset, in_ready=1 the cycle after rst drops.
- Back-to-back: 10 random operand pairs with in_valid and out_ready held high -> each result matches (a+b+cin) mod 256 plus carry, spaced 10 cycles apart.
- With SERIAL_ADDER_SUB_EN: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1; a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
